// File: rtl/fifo_burst_reader.sv
// Burst-read controller: drains a programmed number of words from the FIFO
// dequeue port onto a valid/ready stream through a 2-entry skid buffer.
module fifo_burst_reader #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic [LEN_W-1:0] word_cnt,
    input  logic             fifo_empty,
    output logic             fifo_deq,
    input  logic [WIDTH-1:0] fifo_dout,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_nx;
    logic [LEN_W-1:0] req_left;
    logic [1:0]       occ;
    logic             inflight, inflight_last;
    logic [WIDTH-1:0] d0, d1;
    logic             l0, l1;
    logic             pop, done_nx;
    logic [2:0]       fill;

    // The word returning from the FIFO is presented directly when the
    // buffer is empty, giving first data two cycles after start.
    assign m_valid = (occ != 2'd0) | inflight;
    assign pop     = m_valid & m_ready;
    assign busy    = (state == RUN);
    assign fill    = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};

    assign fifo_deq = (state == RUN) & ~fifo_empty &
                      (req_left != '0) & (fill < 3'd2);

    always_comb begin
        m_data = '0;
        m_last = 1'b0;
        if (occ != 2'd0) begin
            m_data = d0;
            m_last = l0;
        end else if (inflight) begin
            m_data = fifo_dout;
            m_last = inflight_last;
        end
    end

    always_comb begin
        state_nx = state;
        done_nx  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (len != '0) state_nx = RUN;
                    else           done_nx  = 1'b1;
                end
            end
            RUN: begin
                if (pop && m_last) begin
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            done          <= 1'b0;
            word_cnt      <= '0;
            req_left      <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            occ           <= 2'd0;
            d0            <= '0;
            d1            <= '0;
            l0            <= 1'b0;
            l1            <= 1'b0;
        end else begin
            done          <= done_nx;
            inflight      <= fifo_deq;
            inflight_last <= fifo_deq & (req_left == LEN_W'(1));
            occ           <= fill[1:0];
            if (state == IDLE && start) begin
                req_left <= len;
                word_cnt <= '0;
            end else begin
                if (fifo_deq) req_left <= req_left - LEN_W'(1);
                if (pop)      word_cnt <= word_cnt + LEN_W'(1);
            end
            // Keep the queue compacted so the head always sits in entry 0.
            case (occ)
                2'd0: begin
                    if (inflight && !pop) begin
                        d0 <= fifo_dout;
                        l0 <= inflight_last;
                    end
                end
                2'd1: begin
                    if (inflight && pop) begin
                        d0 <= fifo_dout;
                        l0 <= inflight_last;
                    end else if (inflight) begin
                        d1 <= fifo_dout;
                        l1 <= inflight_last;
                    end
                end
                2'd2: begin
                    if (pop) begin
                        d0 <= d1;
                        l0 <= l1;
                        if (inflight) begin
                            d1 <= fifo_dout;
                            l1 <= inflight_last;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader with a behavioural FIFO model.
module tb_fifo_burst_reader;

    logic       clk = 1'b0;
    logic       rstn, start;
    logic [7:0] len;
    logic       busy, done;
    logic [7:0] word_cnt;
    logic       fifo_empty, fifo_deq;
    logic [7:0] fifo_dout;
    logic       m_valid, m_ready, m_last;
    logic [7:0] m_data;

    logic       push_en;
    logic [7:0] push_data;
    int         rdy_mode;

    int n_chk = 0, n_pass = 0;
    int pop_n = 0, deq_n = 0, out_n = 0;
    int stall_bad = 0, over_bad = 0, deq_empty_bad = 0;
    int rcyc = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h0;
    logic [8:0] got_w [256];
    logic [7:0] fq [$];

    fifo_burst_reader #(.WIDTH(8), .LEN_W(8)) dut (
        .clk(clk), .rstn(rstn), .start(start), .len(len),
        .busy(busy), .done(done), .word_cnt(word_cnt),
        .fifo_empty(fifo_empty), .fifo_deq(fifo_deq), .fifo_dout(fifo_dout),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
    );

    always #5 clk = ~clk;

    // FIFO model: registered empty flag, read data one cycle after deq
    always @(posedge clk) begin
        if (!rstn) begin
            fq.delete();
            fifo_dout  <= 8'h0;
            fifo_empty <= 1'b1;
        end else begin
            if (fifo_deq) fifo_dout <= fq.pop_front();
            if (push_en)  fq.push_back(push_data);
            fifo_empty <= (fq.size() == 0);
        end
    end

    always @(posedge clk) begin
        rcyc <= rcyc + 1;
        if (rdy_mode == 0) m_ready <= 1'b1;
        else m_ready <= (rcyc % 4 == 0) || (rcyc % 4 == 3);
    end

    always @(negedge clk) begin
        if (fifo_deq && fifo_empty) deq_empty_bad++;
        if (prev_stall && (!m_valid || m_data != prev_data)) stall_bad++;
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
        if (!rstn) out_n = 0;
        else out_n = out_n + int'(fifo_deq) - int'(m_valid && m_ready);
        if (out_n > 2) over_bad++;
        if (m_valid && m_ready) begin
            got_w[pop_n % 256] = {m_last, m_data};
            pop_n++;
        end
        if (fifo_deq) deq_n++;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            push_en   = 1'b1;
            push_data = base + 8'(i);
            step();
        end
        push_en = 1'b0;
        step();
    endtask

    task automatic go(input logic [7:0] l);
        start = 1'b1;
        len   = l;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int bound);
        bit ok = 0;
        for (int i = 0; i < bound && !ok; i++) begin
            @(negedge clk);
            if (done) ok = 1;
        end
        chk(tag, int'(ok), 1);
    endtask

    task automatic chk_words(input string tag, input int b,
                             input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++)
            chk(tag, int'(got_w[(b + i) % 256]),
                (i == n - 1 ? 256 : 0) + int'(base) + i);
    endtask

    initial begin
        int b, d;
        rstn = 1'b0; start = 1'b0; len = 8'h0;
        push_en = 1'b0; push_data = 8'h0; rdy_mode = 0;
        step(); step();
        @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_valid", int'(m_valid), 0);
        chk("rst_deq", int'(fifo_deq), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_cnt", int'(word_cnt), 0);
        step();
        rstn = 1'b1;
        step();

        // full-rate burst of 4, exact cycle timing
        preload(8'h10, 4);
        go(4);
        @(negedge clk);
        chk("t1_busy", int'(busy), 1);
        chk("t1_deq", int'(fifo_deq), 1);
        chk("t1_valid0", int'(m_valid), 0);
        for (int k = 0; k < 4; k++) begin
            step();
            @(negedge clk);
            chk("t1_valid", int'(m_valid), 1);
            chk("t1_data", int'(m_data), 'h10 + k);
            chk("t1_last", int'(m_last), k == 3 ? 1 : 0);
        end
        step();
        @(negedge clk);
        chk("t1_done", int'(done), 1);
        chk("t1_cnt", int'(word_cnt), 4);
        chk("t1_idle", int'(busy), 0);
        step();
        @(negedge clk);
        chk("t1_done_pulse", int'(done), 0);

        // backpressure pattern
        rdy_mode = 1;
        preload(8'h20, 4);
        b = pop_n; d = deq_n;
        go(4);
        wait_done("t2_done", 80);
        chk("t2_pops", pop_n - b, 4);
        chk("t2_deqs", deq_n - d, 4);
        chk_words("t2_word", b, 8'h20, 4);
        chk("t2_stall", stall_bad, 0);
        chk("t2_over", over_bad, 0);
        rdy_mode = 0;
        step();

        // FIFO runs dry mid-burst
        preload(8'h30, 2);
        b = pop_n; d = deq_n;
        go(4);
        repeat (5) step();
        preload(8'h32, 2);
        wait_done("t3_done", 40);
        chk("t3_deqs", deq_n - d, 4);
        chk("t3_deq_empty", deq_empty_bad, 0);
        chk_words("t3_word", b, 8'h30, 4);
        step();

        // zero-length burst, then start ignored during RUN
        d = deq_n;
        go(0);
        @(negedge clk);
        chk("t4_done0", int'(done), 1);
        chk("t4_busy0", int'(busy), 0);
        chk("t4_cnt0", int'(word_cnt), 0);
        step();
        chk("t4_nodeq", deq_n - d, 0);
        preload(8'h40, 4);
        b = pop_n; d = deq_n;
        go(3);
        go(5);
        wait_done("t4_done3", 40);
        chk("t4_pops", pop_n - b, 3);
        chk_words("t4_word", b, 8'h40, 3);
        repeat (3) step();
        chk("t4_deqs", deq_n - d, 3);
        chk("t4_cnt3", int'(word_cnt), 3);
        b = pop_n;
        go(1);
        wait_done("t4_done1", 20);
        chk_words("t4_left", b, 8'h43, 1);
        step();

        // reset in the middle of a burst
        preload(8'h50, 5);
        b = pop_n;
        go(5);
        for (int i = 0; i < 30 && pop_n - b < 2; i++) @(negedge clk);
        chk("t5_two", pop_n - b, 2);
        step();
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        @(negedge clk);
        chk("t5_busy", int'(busy), 0);
        chk("t5_done", int'(done), 0);
        chk("t5_deq", int'(fifo_deq), 0);
        chk("t5_valid", int'(m_valid), 0);
        chk("t5_last", int'(m_last), 0);
        chk("t5_data", int'(m_data), 0);
        chk("t5_cnt", int'(word_cnt), 0);
        step();
        d = deq_n;
        preload(8'h66, 1);
        repeat (3) step();
        chk("t5_nodeq", deq_n - d, 0);
        b = pop_n;
        go(1);
        wait_done("t5_done1", 20);
        chk("t5_pops", pop_n - b, 1);
        chk_words("t5_word", b, 8'h66, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
